// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The slave side is the subtractor; the master side is the producer and consumer.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_diff,
        input  out_borrow
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_diff,
        output out_borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B computed LSB-first, one bit per clock,
// with a single borrow flop. Result and final borrow are held until consumed.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_d;
    logic               brw_q;
    logic               brw_d;
    logic               diff_bit;
    logic [CNT_W-1:0]   cnt_q;

    // One full-subtractor slice on the current LSBs of the operand shifters.
    always_comb begin
        diff_bit = a_q[0] ^ b_q[0] ^ brw_q;
        brw_d    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
        res_d    = (res_q >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));
    end

    // Operands shift right so bit i sits at position 0 on the i-th RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_b;
                        brw_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    brw_q <= brw_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_diff   = res_q;
    assign bus.out_borrow = brw_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances
// compared against an arithmetic reference model.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Reference: unsigned subtraction modulo 2^w, borrow when A < B.
    function automatic int unsigned ref_diff(input int unsigned a, input int unsigned b,
                                             input int unsigned w);
        int unsigned m;
        m = 32'd1 << w;
        return (a + m - b) % m;
    endfunction

    function automatic logic ref_borrow(input int unsigned a, input int unsigned b);
        return (a < b);
    endfunction

    // Launch one operation on the WIDTH=8 DUT and wait (bounded) for out_valid.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] d, output logic br,
                           output int lat, output bit ok);
        @(negedge clk);
        bus8.in_valid  = 1'b1;
        bus8.in_a      = a;
        bus8.in_b      = b;
        bus8.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        lat = 0;
        while (bus8.out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ok = (bus8.out_valid === 1'b1);
        d  = bus8.out_diff;
        br = bus8.out_borrow;
    endtask

    task automatic release8();
        bus8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 ||
            bus8.out_diff !== 8'h00 || bus8.out_borrow !== 1'b0) begin
            n_err++;
            $display("FAIL reset8: rdy=%b vld=%b diff=%h brw=%b expected 1 0 00 0",
                     bus8.in_ready, bus8.out_valid, bus8.out_diff, bus8.out_borrow);
        end
        n_cmp++;
        if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 ||
            bus1.out_diff !== 1'b0 || bus1.out_borrow !== 1'b0) begin
            n_err++;
            $display("FAIL reset1: rdy=%b vld=%b diff=%b brw=%b expected 1 0 0 0",
                     bus1.in_ready, bus1.out_valid, bus1.out_diff, bus1.out_borrow);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_after_reset: vld=%b rdy=%b expected 0 1",
                     bus8.out_valid, bus8.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic br;
        int lat;
        bit ok;
        run_op8(8'd200, 8'd55, d, br, lat, ok);
        n_cmp++;
        if (!ok || lat != 8) begin
            n_err++;
            $display("FAIL basic_latency: got %0d (valid=%0d) expected 8", lat, ok);
        end
        n_cmp++;
        if (d !== 8'h91 || br !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result: got %h/%b expected 91/0", d, br);
        end
        release8();
        n_cmp++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_handshake: rdy=%b vld=%b expected 1 0",
                     bus8.in_ready, bus8.out_valid);
        end
    endtask

    task automatic test_corners();
        logic [7:0] ta[5] = '{8'd3, 8'h00, 8'hFF, 8'h00, 8'hFF};
        logic [7:0] tb[5] = '{8'd5, 8'h00, 8'hFF, 8'hFF, 8'h00};
        logic [7:0] d;
        logic br;
        int lat;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            run_op8(ta[i], tb[i], d, br, lat, ok);
            n_cmp++;
            if (!ok || d !== 8'(ref_diff(ta[i], tb[i], 8)) || br !== ref_borrow(ta[i], tb[i])) begin
                n_err++;
                $display("FAIL corner %h-%h: got %h/%b expected %h/%b", ta[i], tb[i], d, br,
                         8'(ref_diff(ta[i], tb[i], 8)), ref_borrow(ta[i], tb[i]));
            end
            release8();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d;
        logic br;
        int lat;
        bit ok;
        run_op8(8'd100, 8'd1, d, br, lat, ok);
        n_cmp++;
        if (!ok || d !== 8'd99 || br !== 1'b0) begin
            n_err++;
            $display("FAIL bp_result: got %0d/%b expected 99/0", d, br);
        end
        for (int i = 0; i < 5; i++) begin
            bus8.in_valid = 1'b1;
            bus8.in_a     = 8'($urandom);
            bus8.in_b     = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0 ||
                bus8.out_diff !== 8'd99 || bus8.out_borrow !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cyc%0d: vld=%b rdy=%b diff=%0d brw=%b expected 1 0 99 0",
                         i, bus8.out_valid, bus8.in_ready, bus8.out_diff, bus8.out_borrow);
            end
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.out_ready = 1'b0;
        n_cmp++;
        if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: vld=%b rdy=%b expected 0 1", bus8.out_valid, bus8.in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_single_hs: vld=%b rdy=%b expected 0 1", bus8.out_valid, bus8.in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] d;
        logic br;
        int lat;
        bit ok;
        @(negedge clk);
        bus8.in_valid  = 1'b1;
        bus8.in_a      = 8'hF0;
        bus8.in_b      = 8'h0F;
        bus8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus8.out_valid !== 1'b0 || bus8.out_diff !== 8'h00 ||
            bus8.out_borrow !== 1'b0 || bus8.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_run_reset: vld=%b diff=%h brw=%b rdy=%b expected 0 00 0 1",
                     bus8.out_valid, bus8.out_diff, bus8.out_borrow, bus8.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            n_cmp++;
            if (bus8.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL discarded_op: vld=%b expected 0", bus8.out_valid);
            end
        end
        bus8.out_ready = 1'b0;
        run_op8(8'd10, 8'd20, d, br, lat, ok);
        n_cmp++;
        if (!ok || lat != 8 || d !== 8'hF6 || br !== 1'b1) begin
            n_err++;
            $display("FAIL after_reset_op: got %h/%b lat=%0d expected f6/1 lat=8", d, br, lat);
        end
        release8();
    endtask

    task automatic test_random_backpressure();
        logic [7:0] a, b, d;
        logic br;
        int lat, wait_n;
        bit ok;
        for (int i = 0; i < 12; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            run_op8(a, b, d, br, lat, ok);
            n_cmp++;
            if (!ok || lat != 8 || d !== 8'(ref_diff(a, b, 8)) || br !== ref_borrow(a, b)) begin
                n_err++;
                $display("FAIL rand %h-%h: got %h/%b lat=%0d expected %h/%b lat=8",
                         a, b, d, br, lat, 8'(ref_diff(a, b, 8)), ref_borrow(a, b));
            end
            wait_n = int'($urandom_range(0, 3));
            repeat (wait_n) @(negedge clk);
            n_cmp++;
            if (bus8.out_diff !== 8'(ref_diff(a, b, 8)) || bus8.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL rand_hold %h-%h: got %h vld=%b expected %h vld=1",
                         a, b, bus8.out_diff, bus8.out_valid, 8'(ref_diff(a, b, 8)));
            end
            release8();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        int acc_cyc[$];
        logic [7:0] a, b;
        int n_acc = 0;
        int n_res = 0;
        int cyc = 0;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        while (n_res < 16 && cyc < 400) begin
            if (bus8.out_valid === 1'b1) begin
                if (qa.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL b2b_duplicate: result %h with no pending op", bus8.out_diff);
                end else begin
                    a = qa.pop_front();
                    b = qb.pop_front();
                    n_cmp++;
                    if (bus8.out_diff !== 8'(ref_diff(a, b, 8)) || bus8.out_borrow !== ref_borrow(a, b)) begin
                        n_err++;
                        $display("FAIL b2b %h-%h: got %h/%b expected %h/%b", a, b,
                                 bus8.out_diff, bus8.out_borrow, 8'(ref_diff(a, b, 8)), ref_borrow(a, b));
                    end
                end
                n_res++;
            end
            a = 8'($urandom);
            b = 8'($urandom);
            bus8.in_a     = a;
            bus8.in_b     = b;
            bus8.in_valid = (n_acc < 16);
            if (bus8.in_ready === 1'b1 && n_acc < 16) begin
                qa.push_back(a);
                qb.push_back(b);
                acc_cyc.push_back(cyc);
                n_acc++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b0;
        n_cmp++;
        if (n_res != 16 || n_acc != 16 || qa.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count: results=%0d accepts=%0d pending=%0d expected 16 16 0",
                     n_res, n_acc, qa.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_cmp++;
            if (acc_cyc[i] - acc_cyc[i-1] != 10) begin
                n_err++;
                $display("FAIL b2b_spacing %0d: got %0d cycles expected 10", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    task automatic test_width1();
        int lat;
        logic a, b;
        for (int i = 0; i < 4; i++) begin
            a = 1'(i >> 1);
            b = 1'(i);
            @(negedge clk);
            bus1.in_valid  = 1'b1;
            bus1.in_a      = a;
            bus1.in_b      = b;
            bus1.out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            bus1.in_valid = 1'b0;
            lat = 0;
            while (bus1.out_valid !== 1'b1 && lat < 16) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            n_cmp++;
            if (lat != 1 || bus1.out_diff !== 1'(ref_diff(a, b, 1)) || bus1.out_borrow !== ref_borrow(a, b)) begin
                n_err++;
                $display("FAIL w1 %b-%b: got %b/%b lat=%0d expected %b/%b lat=1", a, b,
                         bus1.out_diff, bus1.out_borrow, lat, 1'(ref_diff(a, b, 1)), ref_borrow(a, b));
            end
            bus1.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus1.out_ready = 1'b0;
            n_cmp++;
            if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL w1_handshake: rdy=%b vld=%b expected 1 0", bus1.in_ready, bus1.out_valid);
            end
        end
    endtask

    initial begin
        bus8.in_valid  = 1'b0;
        bus8.in_a      = '0;
        bus8.in_b      = '0;
        bus8.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_a      = '0;
        bus1.in_b      = '0;
        bus1.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_mid_run();
        test_random_backpressure();
        test_back_to_back();
        test_width1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
